alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one alu instance between two requesters (e.g. EX stage, branch/addr unit).
//  - Arbitrates round-robin and latches the winner's op/operands.
//  - Drives the ALU for EXEC_CYCLES cycles, then returns y/zero to the winner.
//  - Owns alu_ctrl: parks the ALU at `OFF when no operation is in flight.
// PARAMETERS
//  WIDTH        32  operand/result width (matches alu)
//  EXEC_CYCLES  1   cycles operands are held on the ALU before y/zero are sampled (>=1)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous reset, active low
//  req0_valid  in   1      requester 0 has an op
//  req0_ready  out  1      requester 0 op accepted this cycle (valid&&ready)
//  req0_op     in   3      alu_ctrl encoding (`AND/`OR/`ADD/`SUB/`SLT)
//  req0_a      in   WIDTH  operand a
//  req0_b      in   WIDTH  operand b
//  rsp0_valid  out  1      one-cycle pulse: rsp0_y/zero/err valid
//  rsp0_y      out  WIDTH  result
//  rsp0_zero   out  1      ALU zero flag
//  rsp0_err    out  1      op was illegal
//  req1_*, rsp1_*  same set for requester 1
//  alu_a       out  WIDTH  to alu a
//  alu_b       out  WIDTH  to alu b
//  alu_ctrl    out  3      to alu alu_ctrl
//  alu_y       in   WIDTH  from alu y
//  alu_zero    in   1      from alu zero
//  busy        out  1      high in EXEC
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
//  - All rsp*_valid/y/zero/err = 0; busy = 0.
//  - alu_a = alu_b = 0; alu_ctrl = `OFF.
//  FSM IDLE:
//  - alu_ctrl = `OFF; alu_a = alu_b = 0.
//  - grant (combinational):
//    - both valid -> requester != last_grant;
//    - one valid -> that one;
//    - none -> no grant.
//  - reqN_ready = (state==IDLE) && grant==N; at most one ready high per cycle.
//  - Handshake at edge: latch op, a, b, id; cnt <= EXEC_CYCLES-1; go EXEC.
//  - Requester holds op/a/b stable while valid and not ready; valid may drop
//    before acceptance without effect.
//  FSM EXEC:
//  - alu_a/alu_b/alu_ctrl driven from latched regs; all ready low; busy high.
//  - cnt decrements each cycle.
//  - At edge with cnt==0:
//    - rspN_y <= alu_y; rspN_zero <= alu_zero; rspN_valid <= 1 for one cycle;
//    - last_grant <= id; state <= IDLE.
//  Timing:
//  - Latency: accept at edge k -> rsp valid in cycle after edge k+EXEC_CYCLES.
//  - Next accept may coincide with the rsp pulse, giving one op per EXEC_CYCLES+1 cycles.
//  Response hold:
//  - rspN_y/zero/err hold until the next response to N; the other requester's
//    rsp outputs are never disturbed.
//  Illegal op (anything other than `AND/`OR/`ADD/`SUB/`SLT, incl. `OFF):
//  - Accepted normally; alu_ctrl stays `OFF in EXEC.
//  - Same latency; response y = 0, zero = 1, err = 1 (alu_y ignored, may be Z).
//  - Legal ops return err = 0.
//  Arithmetic:
//  - No carry/overflow reporting; the result is exactly the ALU's WIDTH-bit y.
//  Reset mid-EXEC:
//  - Op discarded, no rsp pulse; return to reset values immediately.
// TESTING
//  1 req0 valid, op=`ADD, a=8, b=41, EXEC_CYCLES=1 -> ready0 one cycle;
//    rsp0_valid 2 cycles after accept; y=49, zero=0, err=0.
//  2 Both valid from reset, req0 `SUB 41-8, req1 `AND 0xF0&0x3C, held ->
//    req0 wins (y=33), then req1 (y=0x30).
//    Alternation continues while both stay valid.
//  3 req1 `SLT a=0xFFFFFFFD b=0xFFFFFFFB -> y=0, zero=1;
//    then a=0xFFFFFFFB b=0xFFFFFFFD -> y=1; a=5 b=0xFFFFFFFF -> y=0.
//  4 req0 op=`OFF a=1 b=2 -> alu_ctrl stays `OFF; rsp0 y=0, zero=1, err=1.
//  5 EXEC_CYCLES=3, req0 `OR 0x0F|0xF0 -> alu_* stable 3 cycles, ready low;
//    busy=1; rsp0 y=0xFF 4 cycles after accept.
//  6 rst_n low mid-EXEC -> no rsp pulse; alu_ctrl=`OFF immediately;
//    after release, req1+req0 tie -> req0 granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin front end that lets two requesters share a single ALU. The
// winner's op/operands are latched and held on the ALU for EXEC_CYCLES
// cycles, then y/zero are returned to the winner as a one-cycle pulse.
// Illegal ops are accepted but never reach the ALU (alu_ctrl stays `OFF).

`ifndef AND
`define AND 3'b000
`endif
`ifndef OR
`define OR  3'b001
`endif
`ifndef ADD
`define ADD 3'b010
`endif
`ifndef OFF
`define OFF 3'b011
`endif
`ifndef SUB
`define SUB 3'b110
`endif
`ifndef SLT
`define SLT 3'b111
`endif

module alu_share_arbiter #(
   parameter int WIDTH       = 32,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_y,
   output logic             rsp0_zero,
   output logic             rsp0_err,
   // requester 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_y,
   output logic             rsp1_zero,
   output logic             rsp1_err,
   // shared ALU
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zero,
   output logic             busy
);

   // Counter only needs to reach EXEC_CYCLES-1; keep at least one bit.
   localparam int            CW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_CYCLES - 1);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state;
   logic             last_grant;
   logic             lat_id;
   logic             lat_legal;
   logic [CW-1:0]    cnt;

   logic             gnt_vld;
   logic             gnt_id;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_legal;
   logic [WIDTH-1:0] res_y;
   logic             res_zero;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == `AND) || (op == `OR) || (op == `ADD) ||
             (op == `SUB) || (op == `SLT);
   endfunction

   // Round-robin grant: on a tie the requester that did not win last goes.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = ~last_grant;
      end else if (req0_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b0;
      end else if (req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   // Steer the winning request's fields toward the latch.
   always_comb begin
      sel_op    = gnt_id ? req1_op : req0_op;
      sel_a     = gnt_id ? req1_a  : req0_a;
      sel_b     = gnt_id ? req1_b  : req0_b;
      sel_legal = op_legal(sel_op);
   end

   // Illegal ops never drove the ALU, so its output is ignored (may be Z).
   always_comb begin
      res_y    = lat_legal ? alu_y    : '0;
      res_zero = lat_legal ? alu_zero : 1'b1;
   end

   assign req0_ready = (state == IDLE) && gnt_vld && !gnt_id;
   assign req1_ready = (state == IDLE) && gnt_vld &&  gnt_id;

   // Arbiter FSM; ALU drive, busy and responses are all registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_id     <= 1'b0;
         lat_legal  <= 1'b0;
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= `OFF;
         busy       <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp0_y     <= '0;
         rsp0_zero  <= 1'b0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_y     <= '0;
         rsp1_zero  <= 1'b0;
         rsp1_err   <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  lat_id    <= gnt_id;
                  lat_legal <= sel_legal;
                  alu_a     <= sel_a;
                  alu_b     <= sel_b;
                  alu_ctrl  <= sel_legal ? sel_op : `OFF;
                  cnt       <= CNT_INIT;
                  busy      <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  // Only the winner's response registers are touched.
                  if (lat_id) begin
                     rsp1_valid <= 1'b1;
                     rsp1_y     <= res_y;
                     rsp1_zero  <= res_zero;
                     rsp1_err   <= ~lat_legal;
                  end else begin
                     rsp0_valid <= 1'b1;
                     rsp0_y     <= res_y;
                     rsp0_zero  <= res_zero;
                     rsp0_err   <= ~lat_legal;
                  end
                  last_grant <= lat_id;
                  alu_a      <= '0;
                  alu_b      <= '0;
                  alu_ctrl   <= `OFF;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
